run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer.sv | 84 ++++++++
 tb/tb_run_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: host-started core run control with a reset pulse, end-of-program detect and cycle-limit timeout.
module run_sequencer #(
  parameter int D       = 12,
  parameter int DONE_PC = 105,
  parameter int CW      = 16,
  parameter int RST_CYC = 2,
  parameter int MAX_CYC = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_reset,
  output logic          core_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  typedef enum logic [2:0] {IDLE, CLR, RUN, FINISH, ABORT} state_t;
  state_t r_state, w_next;
  logic [RW-1:0] r_clr, w_clr;
  logic [CW-1:0] r_cycles, w_cycles;
  logic r_done, w_done, r_timeout, w_timeout;
  logic w_pc_hit, w_limit;
  assign w_pc_hit = prog_ctr == D'(DONE_PC);
  assign w_limit  = r_cycles == CW'(MAX_CYC - 1);
  always_comb begin
    w_next    = r_state;
    w_clr     = r_clr;
    w_cycles  = r_cycles;
    w_done    = r_done;
    w_timeout = r_timeout;
    case (r_state)
      IDLE: if (req) begin
        w_next    = CLR;
        w_clr     = '0;
        w_cycles  = '0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
      end
      CLR: begin
        w_clr  = r_clr + 1'b1;
        w_next = (r_clr == RW'(RST_CYC - 1)) ? RUN : CLR;
      end
      RUN: begin
        w_cycles = r_cycles + 1'b1;
        // a program-end match on the limit edge still counts as a normal finish
        if (w_pc_hit) begin
          w_next = FINISH;
          w_done = 1'b1;
        end else if (w_limit) begin
          w_next    = ABORT;
          w_done    = 1'b1;
          w_timeout = 1'b1;
        end
      end
      FINISH, ABORT: w_next = req ? r_state : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_clr     <= '0;
      r_cycles  <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_clr     <= w_clr;
      r_cycles  <= w_cycles;
      r_done    <= w_done;
      r_timeout <= w_timeout;
    end
  end
  assign core_reset = (r_state == IDLE) || (r_state == CLR);
  assign core_en    = r_state == RUN;
  assign busy       = (r_state == CLR) || (r_state == RUN);
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign cycles     = r_cycles;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed checks of run_sequencer at default limit and with MAX_CYC=20.
module tb_run_sequencer;
  logic clk, reset, req, l_req, mode;
  logic [11:0] pc, l_pc;
  logic core_reset, core_en, busy, done, timeout;
  logic l_core_reset, l_core_en, l_busy, l_done, l_timeout;
  logic [15:0] cycles, l_cycles;
  int n_chk, n_fail, run_n, l_run;
  typedef struct {int cyc; bit to;} exp_t;
  exp_t sb[$];

  run_sequencer u_dut (
    .clk(clk), .reset(reset), .req(req), .prog_ctr(pc),
    .core_reset(core_reset), .core_en(core_en), .busy(busy),
    .done(done), .timeout(timeout), .cycles(cycles)
  );
  run_sequencer #(.MAX_CYC(20)) u_lim (
    .clk(clk), .reset(reset), .req(l_req), .prog_ctr(l_pc),
    .core_reset(l_core_reset), .core_en(l_core_en), .busy(l_busy),
    .done(l_done), .timeout(l_timeout), .cycles(l_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // run_n = k just before the k-th RUN edge, so the counting core presents k-1 there
  always @(negedge clk) begin
    if (core_en) begin run_n = run_n + 1; pc = 12'(run_n - 1); end
    else begin run_n = 0; pc = 12'd0; end
    if (l_core_en) l_run = l_run + 1;
    else l_run = 0;
    l_pc = (mode && l_run == 20) ? 12'd105 : 12'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit lim);
    int k = 0;
    while (!(lim ? l_done : done) && k < 300) begin @(negedge clk); k++; end
    chk("done_wait", {31'd0, lim ? l_done : done}, 32'd1);
  endtask

  task automatic pop_cmp(input bit lim);
    exp_t e;
    if (sb.size() == 0) begin chk("sb_empty", 32'd0, 32'd1); return; end
    e = sb.pop_front();
    chk("sb_cycles", {16'd0, lim ? l_cycles : cycles}, e.cyc);
    chk("sb_timeout", {31'd0, lim ? l_timeout : timeout}, {31'd0, e.to});
    chk("sb_busy", {31'd0, lim ? l_busy : busy}, 32'd0);
    chk("sb_core_en", {31'd0, lim ? l_core_en : core_en}, 32'd0);
    chk("sb_core_reset", {31'd0, lim ? l_core_reset : core_reset}, 32'd0);
  endtask

  initial begin
    int k;
    n_chk = 0; n_fail = 0; run_n = 0; l_run = 0;
    reset = 1'b0; req = 1'b0; l_req = 1'b0; mode = 1'b0; pc = '0; l_pc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_core_reset", {31'd0, core_reset}, 1);
    chk("rst_core_en", {31'd0, core_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_timeout", {31'd0, timeout}, 0);
    chk("rst_cycles", {16'd0, cycles}, 0);
    chk("rst_l_done", {31'd0, l_done}, 0);
    req = 1'b1;
    sb.push_back('{cyc: 106, to: 1'b0});
    @(negedge clk);
    chk("clr1_done", {31'd0, done}, 0);
    chk("clr1_cycles", {16'd0, cycles}, 0);
    chk("clr1_busy", {31'd0, busy}, 1);
    chk("clr1_core_reset", {31'd0, core_reset}, 1);
    chk("clr1_core_en", {31'd0, core_en}, 0);
    req = 1'b0;
    @(negedge clk);
    chk("clr2_core_reset", {31'd0, core_reset}, 1);
    req = 1'b1;
    @(negedge clk);
    chk("run_core_reset", {31'd0, core_reset}, 0);
    chk("run_core_en", {31'd0, core_en}, 1);
    chk("run_busy", {31'd0, busy}, 1);
    wait_done(0);
    pop_cmp(0);
    repeat (10) @(negedge clk);
    chk("hold_busy", {31'd0, busy}, 0);
    chk("hold_done", {31'd0, done}, 1);
    chk("hold_cycles", {16'd0, cycles}, 106);
    req = 1'b0;
    @(negedge clk);
    chk("idle_core_reset", {31'd0, core_reset}, 1);
    chk("idle_done", {31'd0, done}, 1);
    repeat (3) @(negedge clk);
    chk("idle_cycles", {16'd0, cycles}, 106);
    chk("idle_done2", {31'd0, done}, 1);
    req = 1'b1;
    @(negedge clk);
    chk("restart_done", {31'd0, done}, 0);
    chk("restart_cycles", {16'd0, cycles}, 0);
    chk("restart_busy", {31'd0, busy}, 1);
    k = 0;
    while (cycles != 16'd50 && k < 100) begin @(negedge clk); k++; end
    chk("reach50", {16'd0, cycles}, 50);
    #1 reset = 1'b0; req = 1'b0;
    #1;
    chk("arst_core_reset", {31'd0, core_reset}, 1);
    chk("arst_core_en", {31'd0, core_en}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_timeout", {31'd0, timeout}, 0);
    chk("arst_cycles", {16'd0, cycles}, 0);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_done", {31'd0, done}, 0);
    req = 1'b1;
    sb.push_back('{cyc: 106, to: 1'b0});
    @(negedge clk);
    chk("new_cycles", {16'd0, cycles}, 0);
    chk("new_busy", {31'd0, busy}, 1);
    wait_done(0);
    pop_cmp(0);
    req = 1'b0;
    mode = 1'b0;
    l_req = 1'b1;
    sb.push_back('{cyc: 20, to: 1'b1});
    @(negedge clk);
    wait_done(1);
    pop_cmp(1);
    l_req = 1'b0;
    @(negedge clk);
    chk("l_idle_timeout", {31'd0, l_timeout}, 1);
    chk("l_idle_done", {31'd0, l_done}, 1);
    mode = 1'b1;
    l_req = 1'b1;
    @(negedge clk);
    chk("l_start_timeout", {31'd0, l_timeout}, 0);
    chk("l_start_done", {31'd0, l_done}, 0);
    sb.push_back('{cyc: 20, to: 1'b0});
    wait_done(1);
    pop_cmp(1);
    l_req = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
